// File: rtl/hamming72_pkg.sv
// Shared SECDED (72,64) definitions used by both the encoder and the decoder.
// Codeword layout: bit 0 = overall parity, bits 1,2,4,8,16,32,64 = P0..P6,
// all remaining bits 3..71 carry data bits 0..63 in ascending order.
package hamming72_pkg;

  localparam int unsigned CW_W    = 72;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned SYN_W   = 7;
  localparam int unsigned NUM_PAR = 7;

  localparam int unsigned PAR_POS [NUM_PAR] = '{1, 2, 4, 8, 16, 32, 64};

  typedef enum logic [1:0] {
    ErrNone,
    ErrSingle,
    ErrDouble
  } err_class_e;

  // True for index 0 (overall parity) and for every power of two (Hamming parity).
  function automatic bit is_par_pos(int unsigned i);
    return (i == 0) || ((i & (i - 1)) == 0);
  endfunction

  // Codeword index holding data bit j.
  function automatic int unsigned data_idx(int unsigned j);
    int unsigned cnt;
    int unsigned idx;
    cnt = 0;
    idx = 0;
    for (int unsigned i = 3; i < CW_W; i++) begin
      if (!is_par_pos(i)) begin
        if (cnt == j) idx = i;
        cnt++;
      end
    end
    return idx;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int unsigned j = 0; j < DATA_W; j++) begin
      d[j] = cw[data_idx(j)];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming72_decoder_if.sv
// Handshake bundle for the SECDED decoder.
//   in_valid/in_ready/code_in  : upstream codeword channel
//   out_valid/out_ready        : downstream result channel
//   data_out/err_single/err_double/err_pos : result payload
// slave = decoder side, master = producer/consumer side.
interface hamming72_decoder_if;
  import hamming72_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              err_single;
  logic              err_double;
  logic [SYN_W-1:0]  err_pos;

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, err_single, err_double, err_pos
  );

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, err_single, err_double, err_pos
  );

endinterface

// File: rtl/hamming72_syndrome.sv
// Combinational syndrome/overall-parity generator for a 72-bit codeword.
//   code_i : codeword
//   syn_o  : XOR of the indices of all set bits in 1..71
//   par_o  : XOR of all 72 bits
module hamming72_syndrome
  import hamming72_pkg::*;
(
  input  logic [CW_W-1:0]  code_i,
  output logic [SYN_W-1:0] syn_o,
  output logic             par_o
);

  always_comb begin
    syn_o = '0;
    for (int unsigned i = 1; i < CW_W; i++) begin
      if (code_i[i]) syn_o = syn_o ^ SYN_W'(i);
    end
    par_o = ^code_i;
  end

endmodule

// File: rtl/hamming72_decoder.sv
// Two-stage SECDED decoder for 72-bit codewords with saturating event counters.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : codeword in / corrected data out handshake (slave modport)
//   cnt_clr      : synchronous clear of both counters (wins over increment)
//   corr_count   : accepted outputs flagged err_single
//   uncorr_count : accepted outputs flagged err_double
module hamming72_decoder
  import hamming72_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hamming72_decoder_if.slave  bus,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    corr_count,
  output logic [CNT_W-1:0]    uncorr_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              s1_valid_q;
  logic [CW_W-1:0]   s1_code_q;
  logic [SYN_W-1:0]  s1_syn_q;
  logic              s1_par_q;
  logic [SYN_W-1:0]  syn_d;
  logic              par_d;

  logic              out_valid_q;
  logic [DATA_W-1:0] data_q;
  logic              err_single_q;
  logic              err_double_q;
  logic [SYN_W-1:0]  err_pos_q;
  logic [CNT_W-1:0]  corr_q;
  logic [CNT_W-1:0]  uncorr_q;

  logic              adv1;
  logic              adv2;
  logic              out_fire;
  err_class_e        err_class;
  logic [CW_W-1:0]   cw_fixed;

  hamming72_syndrome u_syndrome (
    .code_i (bus.code_in),
    .syn_o  (syn_d),
    .par_o  (par_d)
  );

  assign adv2     = !out_valid_q || bus.out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign out_fire = out_valid_q && bus.out_ready;

  // Classify S1 contents and apply single-bit correction before extraction.
  always_comb begin
    err_class = ErrNone;
    cw_fixed  = s1_code_q;
    if (s1_syn_q == '0) begin
      err_class = s1_par_q ? ErrSingle : ErrNone;
    end else if (s1_par_q && (s1_syn_q <= SYN_W'(CW_W - 1))) begin
      err_class = ErrSingle;
      cw_fixed  = s1_code_q ^ (CW_W'(1) << s1_syn_q);
    end else begin
      // Even parity with nonzero syndrome, or a syndrome past the last bit.
      err_class = ErrDouble;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_code_q <= bus.code_in;
        s1_syn_q  <= syn_d;
        s1_par_q  <= par_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      err_pos_q    <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q       <= extract_data(cw_fixed);
        err_single_q <= (err_class == ErrSingle);
        err_double_q <= (err_class == ErrDouble);
        err_pos_q    <= s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      if (out_fire && err_single_q && (corr_q != CntMax)) corr_q <= corr_q + CNT_W'(1);
      if (out_fire && err_double_q && (uncorr_q != CntMax)) uncorr_q <= uncorr_q + CNT_W'(1);
    end
  end

  assign bus.in_ready   = adv1;
  assign bus.out_valid  = out_valid_q;
  assign bus.data_out   = data_q;
  assign bus.err_single = err_single_q;
  assign bus.err_double = err_double_q;
  assign bus.err_pos    = err_pos_q;
  assign corr_count     = corr_q;
  assign uncorr_count   = uncorr_q;

endmodule

// File: tb/tb_hamming72_decoder.sv
// Directed, table-driven bench for hamming72_decoder (counters built 2 bits wide).
module tb_hamming72_decoder;

  localparam int unsigned CntW = 2;
  localparam int unsigned NVec = 10;

  typedef struct {
    logic [71:0] code;
    logic [63:0] data;
    logic        single;
    logic        dbl;
    logic [6:0]  pos;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic            cnt_clr;
  logic [CntW-1:0] corr_count;
  logic [CntW-1:0] uncorr_count;

  int checks;
  int failures;
  int exp_corr;
  int exp_uncorr;
  vec_t vecs [NVec];

  hamming72_decoder_if dif ();

  hamming72_decoder #(
    .CNT_W (CntW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (dif),
    .cnt_clr      (cnt_clr),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one word into an empty pipeline, wait for it, check payload, latency and counters.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    dif.in_valid  = 1'b1;
    dif.code_in   = v.code;
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.in_valid = 1'b0;
    lat = 1;
    while (!dif.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 72'(lat), 72'(2));
    chk({tag, " data"}, 72'(dif.data_out), 72'(v.data));
    chk({tag, " single"}, 72'(dif.err_single), 72'(v.single));
    chk({tag, " double"}, 72'(dif.err_double), 72'(v.dbl));
    chk({tag, " pos"}, 72'(dif.err_pos), 72'(v.pos));
    if (v.single && exp_corr < 3) exp_corr++;
    if (v.dbl && exp_uncorr < 3) exp_uncorr++;
    @(negedge clk);
    chk({tag, " corr_count"}, 72'(corr_count), 72'(exp_corr));
    chk({tag, " uncorr_count"}, 72'(uncorr_count), 72'(exp_uncorr));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr    = 1'b0;
    exp_corr   = 0;
    exp_uncorr = 0;
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    int saw_full;
    int stale;
    logic hold_pending;
    logic [63:0] held;
    logic acc_in;
    logic acc_out;
    vec_t v;

    checks     = 0;
    failures   = 0;
    exp_corr   = 0;
    exp_uncorr = 0;

    vecs[0] = '{72'h0,                        64'h0, 1'b0, 1'b0, 7'd0};
    vecs[1] = '{72'hF,                        64'h1, 1'b0, 1'b0, 7'd0};
    vecs[2] = '{72'h7,                        64'h1, 1'b1, 1'b0, 7'd3};
    vecs[3] = '{72'hE,                        64'h1, 1'b1, 1'b0, 7'd0};
    vecs[4] = '{72'h27,                       64'h2, 1'b0, 1'b1, 7'd6};
    vecs[5] = '{72'h01_0000_0001_0001_0116,   64'h0, 1'b0, 1'b1, 7'd127};
    vecs[6] = '{72'h80_0000_0000_0000_0000,   64'h0, 1'b1, 1'b0, 7'd71};
    vecs[7] = '{72'h01_0000_0000_0000_0101,   64'h0, 1'b0, 1'b1, 7'd72};
    vecs[8] = '{72'h33,                       64'h2, 1'b0, 1'b0, 7'd0};
    vecs[9] = '{72'h13,                       64'h2, 1'b1, 1'b0, 7'd5};

    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    dif.in_valid  = 1'b0;
    dif.code_in   = '0;
    dif.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    chk("reset out_valid", 72'(dif.out_valid), 72'(0));
    chk("reset data_out", 72'(dif.data_out), 72'(0));
    chk("reset err_single", 72'(dif.err_single), 72'(0));
    chk("reset err_double", 72'(dif.err_double), 72'(0));
    chk("reset err_pos", 72'(dif.err_pos), 72'(0));
    chk("reset corr_count", 72'(corr_count), 72'(0));
    chk("reset uncorr_count", 72'(uncorr_count), 72'(0));
    chk("reset in_ready", 72'(dif.in_ready), 72'(1));
    rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Streaming with out_ready pattern 1,0,0 repeating.
    sent = 0;
    recv = 0;
    cyc = 0;
    saw_full = 0;
    hold_pending = 1'b0;
    held = '0;
    while (recv < 8 && cyc < 80) begin
      @(negedge clk);
      dif.out_ready = (cyc % 3 == 0);
      dif.in_valid  = (sent < 8);
      if (sent < 8) dif.code_in = vecs[sent].code;
      #1;
      if (hold_pending) begin
        chk($sformatf("stall hold valid c%0d", cyc), 72'(dif.out_valid), 72'(1));
        chk($sformatf("stall hold data c%0d", cyc), 72'(dif.data_out), 72'(held));
        hold_pending = 1'b0;
      end
      if ((sent - recv) == 2 && !dif.out_ready) saw_full++;
      chk($sformatf("stream in_ready c%0d", cyc), 72'(dif.in_ready),
          72'(!((sent - recv) == 2 && !dif.out_ready)));
      acc_in  = dif.in_valid && dif.in_ready;
      acc_out = dif.out_valid && dif.out_ready;
      if (acc_out) begin
        chk($sformatf("stream%0d data", recv), 72'(dif.data_out), 72'(vecs[recv].data));
        chk($sformatf("stream%0d single", recv), 72'(dif.err_single), 72'(vecs[recv].single));
        chk($sformatf("stream%0d double", recv), 72'(dif.err_double), 72'(vecs[recv].dbl));
        chk($sformatf("stream%0d pos", recv), 72'(dif.err_pos), 72'(vecs[recv].pos));
      end
      if (dif.out_valid && !dif.out_ready) begin
        hold_pending = 1'b1;
        held = dif.data_out;
      end
      @(posedge clk);
      if (acc_in) sent++;
      if (acc_out) recv++;
      cyc++;
    end
    @(negedge clk);
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    chk("stream all received", 72'(recv), 72'(8));
    chk("stream saw both stages full", 72'(saw_full != 0), 72'(1));

    // Saturation: five single errors into a 2-bit counter.
    pulse_clr();
    chk("clr corr_count", 72'(corr_count), 72'(0));
    chk("clr uncorr_count", 72'(uncorr_count), 72'(0));
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[2], $sformatf("sat%0d", i));
    end
    chk("saturated corr_count", 72'(corr_count), 72'(3));

    // Clear coinciding with an accepted error output.
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.code_in  = vecs[2].code;
    @(negedge clk);
    dif.in_valid = 1'b0;
    @(negedge clk);
    chk("clr+inc out_valid", 72'(dif.out_valid), 72'(1));
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr+inc corr_count", 72'(corr_count), 72'(0));

    // Reset with two words in flight.
    @(negedge clk);
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.code_in   = vecs[1].code;
    @(negedge clk);
    dif.code_in = vecs[2].code;
    @(negedge clk);
    dif.in_valid = 1'b0;
    chk("inflight out_valid", 72'(dif.out_valid), 72'(1));
    chk("inflight in_ready", 72'(dif.in_ready), 72'(0));
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 72'(dif.out_valid), 72'(0));
    @(posedge clk);
    #1;
    chk("reset edge out_valid", 72'(dif.out_valid), 72'(0));
    chk("reset edge data_out", 72'(dif.data_out), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dif.out_ready = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (dif.out_valid) stale++;
    end
    chk("no stale output after reset", 72'(stale), 72'(0));

    // Post-reset sanity on a corrected word.
    v = vecs[9];
    exp_corr   = 0;
    exp_uncorr = 0;
    run_vec(v, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
